// File: rtl/fetch_stage.sv
// fetch_stage: RV32I instruction fetch stage.
// Owns the PC, runs a req/ack handshake with instruction memory, holds each
// fetched word until the downstream stage retires it, and selects the next PC
// (PC+4 / PC+offset / indirect).
// Optional feature macro: FETCH_MISALIGN_TRAP_EN (adds o_Misaligned and TRAP state).
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          MEM_AW   = 32
) (
  input  logic              i_Clock,
  input  logic              i_Reset,
  input  logic              i_Advance,
  input  logic [1:0]        i_PCNextSel,
  input  logic [31:0]       i_Offset,
  input  logic [31:0]       i_IndTarget,
  output logic              o_MemReq,
  output logic [MEM_AW-1:0] o_MemAddr,
  input  logic              i_MemAck,
  input  logic [31:0]       i_MemData,
  output logic [31:0]       o_Inst,
  output logic [31:0]       o_PC,
`ifdef FETCH_MISALIGN_TRAP_EN
  output logic              o_Misaligned,
`endif
  output logic              o_InstValid
);

  localparam logic [31:0] NOP = 32'h0000_0013;

`ifdef FETCH_MISALIGN_TRAP_EN
  typedef enum logic [1:0] {S_START, S_FETCH, S_HOLD, S_TRAP} state_t;
`else
  typedef enum logic [1:0] {S_START, S_FETCH, S_HOLD} state_t;
`endif

  state_t       state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  inst_q, inst_d;
  logic [31:0]  ipc_q, ipc_d;
  logic         vld_q, vld_d;
  logic         mem_req;
  logic signed [31:0] offset_s;
  logic [31:0]  npc_raw;
  logic [31:0]  npc_aligned;
`ifdef FETCH_MISALIGN_TRAP_EN
  logic         mis_q, mis_d;
  logic         npc_misaligned;
`endif

  assign offset_s = i_Offset;

  // Next-PC selection relative to the held instruction's address (wraps mod 2^32).
  always_comb begin
    npc_raw = ipc_q + 32'd4;
    case (i_PCNextSel)
      2'b01:   npc_raw = ipc_q + $unsigned(offset_s);
      2'b10:   npc_raw = i_IndTarget & 32'hFFFF_FFFE;
      default: npc_raw = ipc_q + 32'd4;
    endcase
  end

  assign npc_aligned = npc_raw & 32'hFFFF_FFFC;
`ifdef FETCH_MISALIGN_TRAP_EN
  assign npc_misaligned = |npc_raw[1:0];
`endif

  // Fetch FSM next-state and datapath updates.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    inst_d  = inst_q;
    ipc_d   = ipc_q;
    vld_d   = vld_q;
    mem_req = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
    mis_d   = mis_q;
`endif
    case (state_q)
      // Post-reset dead cycle: any ack seen here belongs to an abandoned transfer.
      S_START: state_d = S_FETCH;
      S_FETCH: begin
        mem_req = 1'b1;
        if (i_MemAck) begin
          inst_d  = i_MemData;
          ipc_d   = pc_q;
          vld_d   = 1'b1;
          state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        if (i_Advance && vld_q) begin
          pc_d    = npc_aligned;
          vld_d   = 1'b0;
          state_d = S_FETCH;
`ifdef FETCH_MISALIGN_TRAP_EN
          if (npc_misaligned) begin
            pc_d    = npc_raw;
            mis_d   = 1'b1;
            state_d = S_TRAP;
          end
`endif
        end
      end
`ifdef FETCH_MISALIGN_TRAP_EN
      // Terminal until reset.
      S_TRAP: state_d = S_TRAP;
`endif
      default: state_d = S_START;
    endcase
  end

  // State and fetch registers; reset is asynchronous so o_MemReq drops at once.
  always_ff @(posedge i_Clock or negedge i_Reset) begin
    if (!i_Reset) begin
      state_q <= S_START;
      pc_q    <= RESET_PC;
      inst_q  <= NOP;
      ipc_q   <= RESET_PC;
      vld_q   <= 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
      mis_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
      ipc_q   <= ipc_d;
      vld_q   <= vld_d;
`ifdef FETCH_MISALIGN_TRAP_EN
      mis_q   <= mis_d;
`endif
    end
  end

  assign o_MemReq    = mem_req;
  assign o_MemAddr   = pc_q[MEM_AW-1:0];
  assign o_Inst      = inst_q;
  assign o_PC        = ipc_q;
  assign o_InstValid = vld_q;
`ifdef FETCH_MISALIGN_TRAP_EN
  assign o_Misaligned = mis_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Testbench for fetch_stage: directed test-plan steps followed by randomized
// fetch/hold/advance transactions checked against a transaction-level PC model.
module tb_fetch_stage;

  localparam logic [31:0] RST_PC = 32'h0000_0100;
  localparam logic [31:0] NOP    = 32'h0000_0013;
`ifdef FETCH_MISALIGN_TRAP_EN
  localparam logic [31:0] RMASK  = 32'hFFFF_FFFC;
`else
  localparam logic [31:0] RMASK  = 32'hFFFF_FFFF;
`endif

  logic        clk;
  logic        rst_n;
  logic        adv;
  logic [1:0]  sel;
  logic [31:0] off;
  logic [31:0] ind;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_data;
  logic [31:0] inst;
  logic [31:0] pc;
  logic        inst_vld;
`ifdef FETCH_MISALIGN_TRAP_EN
  logic        misaligned;
`endif

  int vectors    = 0;
  int miscompares = 0;

  logic [31:0] exp_pc;
  logic [31:0] cur_inst;
  logic [31:0] cur_pc;

  fetch_stage #(.RESET_PC(RST_PC), .MEM_AW(32)) dut (
    .i_Clock     (clk),
    .i_Reset     (rst_n),
    .i_Advance   (adv),
    .i_PCNextSel (sel),
    .i_Offset    (off),
    .i_IndTarget (ind),
    .o_MemReq    (mem_req),
    .o_MemAddr   (mem_addr),
    .i_MemAck    (mem_ack),
    .i_MemData   (mem_data),
    .o_Inst      (inst),
    .o_PC        (pc),
`ifdef FETCH_MISALIGN_TRAP_EN
    .o_Misaligned(misaligned),
`endif
    .o_InstValid (inst_vld)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // One clock: edge happens, then outputs are sampled at the falling edge.
  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Reference next-PC: plain modular arithmetic on the architectural rules.
  function automatic logic [31:0] ref_next(input logic [31:0] p, input logic [1:0] s,
                                           input logic [31:0] o, input logic [31:0] t);
    longint unsigned two32 = 64'h1_0000_0000;
    longint unsigned r;
    if (s == 2'd1)      r = (64'(p) + 64'(o)) % two32;
    else if (s == 2'd2) r = 64'(t) - (64'(t) % 2);
    else                r = (64'(p) + 4) % two32;
    r = r - (r % 4);
    return r[31:0];
  endfunction

  // Reset-release START cycle with a stale ack that must be ignored.
  task automatic start_cycle();
    chk("start_req", {31'd0, mem_req}, 32'd0);
    mem_ack = 1'b1; mem_data = 32'hDEAD_BEEF;
    cyc();
    mem_ack = 1'b0;
    chk("start_next_req", {31'd0, mem_req}, 32'd1);
    chk("start_addr", mem_addr, RST_PC);
    chk("start_vld", {31'd0, inst_vld}, 32'd0);
    chk("start_stale_inst", inst, NOP);
    exp_pc = RST_PC;
  endtask

  // Asynchronous reset asserted between clock edges, then released.
  task automatic reset_now();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_req_async", {31'd0, mem_req}, 32'd0);
    chk("rst_vld", {31'd0, inst_vld}, 32'd0);
    chk("rst_pc", pc, RST_PC);
    chk("rst_inst", inst, NOP);
`ifdef FETCH_MISALIGN_TRAP_EN
    chk("rst_mis", {31'd0, misaligned}, 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    start_cycle();
  endtask

  // Fetch at exp_pc with dly wait cycles before ack; advance noise while invalid.
  task automatic fetch_txn(input int dly, input logic [31:0] data);
    for (int i = 0; i < dly; i++) begin
      chk("wait_req", {31'd0, mem_req}, 32'd1);
      chk("wait_addr", mem_addr, exp_pc);
      chk("wait_vld", {31'd0, inst_vld}, 32'd0);
      mem_ack = 1'b0;
      adv = 1'($urandom_range(0, 1));
      sel = 2'($urandom_range(0, 3));
      off = $urandom;
      cyc();
    end
    chk("ack_req", {31'd0, mem_req}, 32'd1);
    chk("ack_addr", mem_addr, exp_pc);
    adv = 1'b0;
    mem_ack = 1'b1; mem_data = data;
    cyc();
    mem_ack = 1'b0;
    cur_inst = data;
    cur_pc   = exp_pc;
    chk("got_vld", {31'd0, inst_vld}, 32'd1);
    chk("got_inst", inst, cur_inst);
    chk("got_pc", pc, cur_pc);
    chk("got_req", {31'd0, mem_req}, 32'd0);
  endtask

  // Hold for some cycles (stray acks ignored), then retire with a next-PC choice.
  task automatic hold_adv(input int hold, input logic [1:0] s, input logic [31:0] o,
                          input logic [31:0] t);
    for (int i = 0; i < hold; i++) begin
      mem_ack = 1'($urandom_range(0, 1));
      mem_data = $urandom;
      adv = 1'b0;
      cyc();
      mem_ack = 1'b0;
      chk("hold_inst", inst, cur_inst);
      chk("hold_pc", pc, cur_pc);
      chk("hold_vld", {31'd0, inst_vld}, 32'd1);
      chk("hold_req", {31'd0, mem_req}, 32'd0);
    end
    adv = 1'b1; sel = s; off = o; ind = t;
    cyc();
    adv = 1'b0;
    exp_pc = ref_next(cur_pc, s, o, t);
    chk("adv_vld", {31'd0, inst_vld}, 32'd0);
    chk("adv_req", {31'd0, mem_req}, 32'd1);
  endtask

  initial begin
    rst_n = 1'b1; adv = 1'b0; sel = 2'd0; off = 32'd0; ind = 32'd0;
    mem_ack = 1'b0; mem_data = 32'd0;
    exp_pc = RST_PC; cur_inst = NOP; cur_pc = RST_PC;
    #1 rst_n = 1'b0;
    @(negedge clk); @(negedge clk);
    chk("reset_req", {31'd0, mem_req}, 32'd0);
    chk("reset_vld", {31'd0, inst_vld}, 32'd0);
    chk("reset_inst", inst, NOP);
    chk("reset_pc", pc, RST_PC);
`ifdef FETCH_MISALIGN_TRAP_EN
    chk("reset_mis", {31'd0, misaligned}, 32'd0);
`endif
    rst_n = 1'b1;
    start_cycle();

    // First fetch, then sequential advance.
    fetch_txn(0, 32'h0050_0093);
    hold_adv(1, 2'd0, 32'd0, 32'd0);
    chk("seq_addr", mem_addr, 32'h0000_0104);
    // Negative offset.
    fetch_txn(2, $urandom);
    hold_adv(0, 2'd1, 32'hFFFF_FFF8, 32'd0);
    chk("neg_off_addr", mem_addr, 32'h0000_00FC);
    // Indirect with bit 0 set, then select 11 behaving as +4.
    fetch_txn(1, $urandom);
    hold_adv(1, 2'd2, 32'd0, 32'h0000_0201);
    chk("ind_addr", mem_addr, 32'h0000_0200);
    fetch_txn(0, $urandom);
    hold_adv(0, 2'd3, 32'h0000_0040, 32'h0000_0800);
    chk("sel11_addr", mem_addr, 32'h0000_0204);
    // Long ack wait then reset mid-handshake.
    fetch_txn(3, $urandom);
    hold_adv(0, 2'd0, 32'd0, 32'd0);
    mem_ack = 1'b0;
    cyc();
    reset_now();

    // Misaligned offset from o_PC = 0x104.
    fetch_txn(0, $urandom);
    hold_adv(0, 2'd0, 32'd0, 32'd0);
    fetch_txn(1, $urandom);
    chk("pre_mis_pc", pc, 32'h0000_0104);
`ifdef FETCH_MISALIGN_TRAP_EN
    adv = 1'b1; sel = 2'd1; off = 32'd2;
    cyc();
    adv = 1'b0;
    chk("trap_mis", {31'd0, misaligned}, 32'd1);
    chk("trap_req", {31'd0, mem_req}, 32'd0);
    chk("trap_vld", {31'd0, inst_vld}, 32'd0);
    mem_ack = 1'b1; adv = 1'b1;
    cyc(); cyc();
    mem_ack = 1'b0; adv = 1'b0;
    chk("trap_stay_req", {31'd0, mem_req}, 32'd0);
    chk("trap_stay_mis", {31'd0, misaligned}, 32'd1);
    reset_now();
    fetch_txn(0, $urandom);
    hold_adv(0, 2'd0, 32'd0, 32'd0);
    fetch_txn(0, $urandom);
`else
    hold_adv(0, 2'd1, 32'd2, 32'd0);
    chk("mis_clear_addr", mem_addr, 32'h0000_0104);
    fetch_txn(0, $urandom);
`endif

    // PC wrap at top of address space.
    hold_adv(0, 2'd2, 32'd0, 32'hFFFF_FFFD);
    chk("top_addr", mem_addr, 32'hFFFF_FFFC);
    fetch_txn(1, $urandom);
    hold_adv(0, 2'd0, 32'd0, 32'd0);
    chk("wrap_addr", mem_addr, 32'h0000_0000);

    // Randomized transactions.
    for (int n = 0; n < 40; n++) begin
      fetch_txn($urandom_range(0, 3), $urandom);
      hold_adv($urandom_range(0, 2), 2'($urandom_range(0, 3)),
               $urandom & RMASK, $urandom & RMASK);
    end
    fetch_txn(0, $urandom);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
Instruction fetch stage of the single-issue RV32I core; sits directly upstream of the RV32I decoder/controller and drives its instruction input.
- Owns the PC register.
- Runs a req/ack handshake against instruction memory.
- Holds each fetched word stable until the downstream stage retires it.
- Computes the next PC from the controller's next-PC select (PC+4 / PC+offset / indirect).

Parameters:
RESET_PC, 32'h0000_0000, PC loaded on reset; first fetch address.
MEM_AW, 32, instruction memory address width; o_MemAddr = PC[MEM_AW-1:0].

Ports:
i_Clock  in  1  core clock, all state on rising edge
i_Reset  in  1  asynchronous, active-low reset
i_Advance  in  1  downstream retires current instruction this cycle; ignored unless o_InstValid=1
i_PCNextSel  in  2  00 PC+4, 01 PC+offset, 10 indirect, 11 treated as PC+4; sampled only with effective advance
i_Offset  in  32  signed branch/jump offset, relative to o_PC
i_IndTarget  in  32  rs1+imm for JALR
o_MemReq  out  1  fetch request
o_MemAddr  out  MEM_AW  fetch address
i_MemAck  in  1  memory returns i_MemData this cycle
i_MemData  in  32  instruction word
o_Inst  out  32  held instruction, to controller
o_PC  out  32  address of o_Inst
o_InstValid  out  1  o_Inst/o_PC valid

Behaviour:
Reset values (immediate, asynchronous):
- PC = RESET_PC, o_PC = RESET_PC.
- o_Inst = 32'h0000_0013 (NOP), o_InstValid = 0.
- o_MemReq = 0, FSM = START.

FSM states START, FETCH, HOLD (+ TRAP with optional feature):
- START: one cycle after reset release; o_MemReq = 0; an i_MemAck here is stale and is ignored. Next state FETCH.
- FETCH: o_MemReq = 1, o_MemAddr = PC. Address is held stable until ack. On i_MemAck: o_Inst <= i_MemData, o_PC <= PC, o_InstValid <= 1, next state HOLD.
- HOLD: o_MemReq = 0; o_Inst and o_PC frozen. On i_Advance: PC <= next PC, o_InstValid <= 0, next state FETCH.
- An i_MemAck while o_MemReq = 0 is ignored.

Next PC (32-bit, modulo 2^32 wrap, no overflow flag):
- 00/11: o_PC + 4
- 01: o_PC + i_Offset
- 10: {i_IndTarget[31:1], 1'b0}
- Effective next PC has bits [1:0] forced to 00 when the optional feature is off.

Timing and edge cases:
- Latency: ack in cycle N gives o_InstValid = 1 in N+1. Advance in cycle M gives o_MemReq = 1 in M+1. Peak throughput is 1 instruction per 2 cycles.
- Reset mid-handshake: o_MemReq drops asynchronously. Memory is expected to abandon the transfer; any late ack lands in START and is discarded.
- PC wrap: 0xFFFF_FFFC + 4 = 0x0000_0000, fetched normally.

Optional Feature:
Macro FETCH_MISALIGN_TRAP_EN.
- Defined: adds port o_Misaligned (out, 1, reset 0). If the effective next PC has bits [1:0] != 00, then on the advance edge:
  - PC is loaded unaligned and o_Misaligned <= 1;
  - FSM enters TRAP: o_MemReq = 0, o_InstValid = 0;
  - TRAP is left only by reset.
- Not defined: no port and no TRAP state; bits [1:0] of the next PC are silently cleared.

Test Plan:
1. RESET_PC=0x100, release reset -> START cycle o_MemReq=0; next cycle o_MemReq=1, o_MemAddr=0x100; ack with 0x00500093 -> following cycle o_InstValid=1, o_Inst=0x00500093, o_PC=0x100.
2. From 1, i_Advance=1, sel=00 -> o_InstValid=0 next cycle, then o_MemReq=1, o_MemAddr=0x104.
3. o_PC=0x104, sel=01, i_Offset=0xFFFF_FFF8 -> next fetch addr 0x0FC; i_Advance with o_InstValid=0 -> no PC change.
4. sel=10, i_IndTarget=0x201 -> fetch addr 0x200. sel=11 -> fetch addr = o_PC+4.
5. Ack delayed 3 cycles -> o_MemReq=1 and o_MemAddr constant for all 3 cycles, o_InstValid=0. Assert i_Reset=0 mid-wait -> o_MemReq=0 immediately; ack in START cycle ignored.
6. o_PC=0x104, sel=01, i_Offset=0x2 -> with FETCH_MISALIGN_TRAP_EN: o_Misaligned=1, o_MemReq stays 0. Without: fetch addr 0x104.
